// File: rtl/wait_state_memory_if.sv
// rtl/wait_state_memory_if.sv - request/response bus for the wait-state memory
interface wait_state_memory_if;
  logic        Req;
  logic        WE;
  logic [1:0]  Size;
  logic [31:0] Address;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        Ready;
  logic        Fault;
  logic        Busy;

  modport master (
    output Req, WE, Size, Address, WD,
    input  RD, Ready, Fault, Busy
  );

  modport slave (
    input  Req, WE, Size, Address, WD,
    output RD, Ready, Fault, Busy
  );
endinterface

// File: rtl/wait_state_memory.sv
// rtl/wait_state_memory.sv - word-array memory with fixed wait states, lane writes and text protection
module wait_state_memory #(
  parameter int          DEPTH_WORDS = 2048,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] TEXT_BASE   = 32'h0000_0400,
  parameter logic [31:0] TEXT_LIMIT  = 32'h0000_0800,
  parameter bit          TEXT_WP     = 1'b1,
  parameter string       INIT_FILE   = ""
) (
  input logic                clk,
  input logic                reset,
  wait_state_memory_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;
  logic        fault_q, fault_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic              idle;
  logic              accept;
  logic              enter_done;
  logic [31:0]       cur_addr;
  logic              cur_we;
  logic [1:0]        cur_size;
  logic [31:0]       cur_wd;
  logic [IDX_W-1:0]  idx;
  logic              acc_fault;
  logic              mem_we;
  logic [3:0]        wmask;
  logic [31:0]       wdata;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       rd_value;
  logic [31:0]       echo_value;

  // State, counter and latched-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: Req only matters in IDLE, so requests during Busy are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.Req) state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_WAIT: if (cnt_q <= 4'd1) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Access decode; with zero wait states the access completes on the acceptance
  // edge, so the live bus inputs stand in for the not-yet-latched copies
  always_comb begin
    idle       = (state_q == S_IDLE);
    accept     = idle && bus.Req;
    enter_done = (state_d == S_DONE);
    cur_addr   = idle ? bus.Address : addr_q;
    cur_we     = idle ? bus.WE      : we_q;
    cur_size   = idle ? bus.Size    : size_q;
    cur_wd     = idle ? bus.WD      : wd_q;
    idx        = cur_addr[IDX_W+1:2];

    acc_fault = 1'b0;
    if (cur_size == 2'b11) acc_fault = 1'b1;
    if (cur_size == 2'b01 && cur_addr[0]) acc_fault = 1'b1;
    if (cur_size == 2'b10 && cur_addr[1:0] != 2'b00) acc_fault = 1'b1;
    if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) acc_fault = 1'b1;
    if (TEXT_WP && cur_we && cur_addr >= TEXT_BASE && cur_addr < TEXT_LIMIT) acc_fault = 1'b1;

    case (cur_size)
      2'b00:   begin wmask = 4'b0001 << cur_addr[1:0];             wdata = {4{cur_wd[7:0]}};  end
      2'b01:   begin wmask = cur_addr[1] ? 4'b1100 : 4'b0011;      wdata = {2{cur_wd[15:0]}}; end
      default: begin wmask = 4'b1111;                               wdata = cur_wd;            end
    endcase

    rd_word  = mem[idx];
    rd_shift = rd_word >> {cur_addr[1:0], 3'b000};
    case (cur_size)
      2'b00:   begin rd_value = {24'h0, rd_shift[7:0]};  echo_value = {24'h0, cur_wd[7:0]};  end
      2'b01:   begin rd_value = {16'h0, rd_shift[15:0]}; echo_value = {16'h0, cur_wd[15:0]}; end
      default: begin rd_value = rd_shift;                echo_value = cur_wd;                end
    endcase

    mem_we = enter_done && !acc_fault && cur_we;

    addr_d = accept ? bus.Address : addr_q;
    we_d   = accept ? bus.WE      : we_q;
    size_d = accept ? bus.Size    : size_q;
    wd_d   = accept ? bus.WD      : wd_q;

    cnt_d = cnt_q;
    if (accept) cnt_d = 4'(WAIT_CYCLES);
    else if (state_q == S_WAIT && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;

    rd_d    = rd_q;
    fault_d = fault_q;
    if (enter_done) begin
      fault_d = acc_fault;
      if (acc_fault)   rd_d = 32'd0;
      else if (cur_we) rd_d = echo_value;
      else             rd_d = rd_value;
    end
  end

  // Lane-masked write commit on the edge entering DONE; reset drops it
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Outputs decoded from the state; Fault is only visible alongside Ready
  always_comb begin
    bus.Ready = (state_q == S_DONE);
    bus.Busy  = (state_q != S_IDLE);
    bus.Fault = fault_q && (state_q == S_DONE);
    bus.RD    = rd_q;
  end

endmodule
